rr_mux_arb: RTL

- Parametrised successor to the combinational 8:1 mux: N input channels of W bits each.
- Each channel has a valid/ready handshake; one registered output stage drives the output handshake.
- Two modes: fixed select, where the grant goes to channel `sel` as in the plain mux, and round-robin arbitration across all valid channels.
- Sits in front of the 64-bit ALU to merge operand/result streams from several producers onto one bus.

---
 rtl/rr_mux_arb_if.sv | 40 ++++
 rtl/rr_mux_arb.sv | 95 +++++++++
 2 files changed

// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb: N valid/ready input channels and one registered output.
// RR_MUX_ARB_STATS_EN adds the xfer_cnt / last_grant_rr statistics signals.
interface rr_mux_arb_if #(
    parameter int W = 64,
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
`ifdef RR_MUX_ARB_STATS_EN
    logic [15:0]    xfer_cnt;
    logic           last_grant_rr;

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, xfer_cnt, last_grant_rr
    );
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, xfer_cnt, last_grant_rr
    );
`else
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
`endif
endinterface

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready merger with fixed-select or round-robin grant and one registered output stage.
// Optional statistics (xfer_cnt, last_grant_rr) are enabled by defining RR_MUX_ARB_STATS_EN.
module rr_mux_arb #(
    parameter int W = 64,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    rr_mux_arb_if.slave  bus
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] ptr;
    logic          load_en;
    logic [N-1:0]  grant;
    logic          gnt_any;
    logic [SW-1:0] gnt_idx;
    logic [W-1:0]  gnt_data;
    logic          xfer;

    assign load_en = !bus.out_valid || bus.out_ready;

    // Round-robin search is split into two ascending passes (above ptr, then up to ptr)
    // so every index is a loop constant and no modulo arithmetic is needed.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!bus.mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.sel == SW'(i) && bus.in_valid[i]) begin
                    grant[i] = 1'b1;
                    gnt_any  = 1'b1;
                    gnt_idx  = SW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!gnt_any && i > 32'(ptr) && bus.in_valid[i]) begin
                    grant[i] = 1'b1;
                    gnt_any  = 1'b1;
                    gnt_idx  = SW'(i);
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!gnt_any && i <= 32'(ptr) && bus.in_valid[i]) begin
                    grant[i] = 1'b1;
                    gnt_any  = 1'b1;
                    gnt_idx  = SW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) gnt_data = bus.in_data[i*W +: W];
        end
    end

    assign bus.in_ready = load_en ? grant : '0;
    assign xfer         = load_en && gnt_any;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= SW'(N-1);
        end else if (load_en) begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= gnt_data;
                bus.out_ch    <= gnt_idx;
                if (bus.mode) ptr <= gnt_idx;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_MUX_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.xfer_cnt      <= '0;
            bus.last_grant_rr <= 1'b0;
        end else if (xfer) begin
            bus.xfer_cnt      <= bus.xfer_cnt + 16'd1;
            bus.last_grant_rr <= bus.mode;
        end
    end
`endif

endmodule
